cmip_app_cnt_rd: RTL

Snapshot-and-readout engine for a bank of NCH event counters (cmip_app_cnt instances, shared delayed-clear scheme). On request it drives a common clear to all counters. It captures every counter value on the exact edge the delayed clear takes effect, then streams the captured values out one channel per beat over a valid/ready interface to the register/upload path.

---
 rtl/cmip_app_cnt_rd.sv | 131 +++++++++++++
 1 files changed

// File: rtl/cmip_app_cnt_rd.sv
// rtl/cmip_app_cnt_rd.sv - snapshot and stream-out of a counter bank with delayed common clear
// Optional: CMIP_CNT_RD_TIMER_EN adds a free-running snapshot timer (parameter TMR_PERIOD).
module cmip_app_cnt_rd #(
  parameter int NCH     = 8,
  parameter int WDTH    = 16,
  parameter int CLR_LAT = 2
`ifdef CMIP_CNT_RD_TIMER_EN
  , parameter int TMR_PERIOD = 1000
`endif
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_req,
  input  logic [NCH*WDTH-1:0] i_cnt,
  output logic                o_clr,
  output logic                o_busy,
  output logic                o_req_drop,
  output logic                o_dat_vld,
  input  logic                i_dat_rdy,
  output logic [4:0]          o_dat_idx,
  output logic [WDTH-1:0]     o_dat,
  output logic                o_dat_last,
  output logic                o_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [3:0]          wait_q;
  logic [NCH*WDTH-1:0] cap_q;
  logic [4:0]          idx_nxt;
  logic                req_eff;

  assign idx_nxt = o_dat_idx + 5'd1;

`ifdef CMIP_CNT_RD_TIMER_EN
  localparam int TW = (TMR_PERIOD > 1) ? $clog2(TMR_PERIOD) : 1;

  logic [TW-1:0] tmr_q;
  logic          tmr_wrap;

  assign tmr_wrap = (tmr_q == TW'(TMR_PERIOD - 1));
  assign req_eff  = i_req | tmr_wrap;

  // Free-running; snapshots never restart it so the period stays exact.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_wrap ? '0 : tmr_q + TW'(1);
    end
  end
`else
  assign req_eff = i_req;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      wait_q     <= '0;
      cap_q      <= '0;
      o_clr      <= 1'b0;
      o_busy     <= 1'b0;
      o_req_drop <= 1'b0;
      o_dat_vld  <= 1'b0;
      o_dat_idx  <= '0;
      o_dat      <= '0;
      o_dat_last <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_clr      <= 1'b0;
      o_done     <= 1'b0;
      o_req_drop <= req_eff && (state_q != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (req_eff) begin
            state_q <= S_CLR;
            o_clr   <= 1'b1;
            o_busy  <= 1'b1;
          end
        end
        S_CLR: begin
          state_q <= S_WAIT;
          wait_q  <= 4'd1;
        end
        S_WAIT: begin
          // Last cycle before the counters zero: they still hold the full count.
          if (wait_q == 4'(CLR_LAT)) begin
            state_q    <= S_SEND;
            cap_q      <= i_cnt;
            o_dat      <= i_cnt[WDTH-1:0];
            o_dat_idx  <= '0;
            o_dat_vld  <= 1'b1;
            o_dat_last <= (NCH == 1);
          end else begin
            wait_q <= wait_q + 4'd1;
          end
        end
        S_SEND: begin
          if (i_dat_rdy) begin
            if (o_dat_idx == 5'(NCH - 1)) begin
              state_q    <= S_DONE;
              o_dat_vld  <= 1'b0;
              o_dat_last <= 1'b0;
              o_done     <= 1'b1;
            end else begin
              o_dat_idx  <= idx_nxt;
              o_dat      <= cap_q[idx_nxt*WDTH +: WDTH];
              o_dat_last <= (idx_nxt == 5'(NCH - 1));
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          o_busy  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
